// File: rtl/btb_ctrl.sv
// Branch target buffer controller: tracks IF/ID/EX prediction records, resolves
// branches in EX, redirects fetch on mispredict and allocates BTB entries on misses.
module btb_ctrl #(
  parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] fetch_pc,
  input  logic        bt_hit,
  input  logic        bt_branch,
  input  logic [31:0] bt_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  output logic        enable_ram,
  output logic        do_write,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic [15:0] mispredict_cnt
);

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, RECOVER, WRITE} state_t;

  state_t          r_state, w_state_nx;
  rec_t [2:0]      r_rec;          // [0]=IF, [1]=ID, [2]=EX
  logic [31:0]     r_redirect;
  logic            r_mis;
  logic [15:0]     r_cnt;

  rec_t            w_rec_in;
  rec_t            w_ex;
  logic            w_act_taken;
  logic            w_mis;
  logic            w_alloc;
  logic            w_resolve;

  assign w_rec_in    = {1'b1, bt_hit, bt_hit & bt_branch, bt_target};
  assign w_ex        = r_rec[2];
  assign w_act_taken = ex_is_branch & ex_taken;
  assign w_mis       = (w_act_taken != w_ex.pred_taken) |
                       (w_act_taken & w_ex.pred_taken & (ex_target != w_ex.pred_target));
  assign w_alloc     = ex_is_branch & ~w_ex.hit;
  assign w_resolve   = (r_state == RUN) & ~stall & ex_valid & w_ex.valid;

  assign mispredict_cnt = r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rec      <= '0;
      r_redirect <= '0;
      r_mis      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nx;
      if (!stall)
        r_rec <= {r_rec[1], r_rec[0], w_rec_in};
      // wrong-path instructions in IF/ID are killed even while stalled
      if (flush) begin
        r_rec[0].valid <= 1'b0;
        r_rec[1].valid <= 1'b0;
      end
      if (w_resolve) begin
        r_redirect <= w_act_taken ? ex_target : ex_pc + 32'd4;
        r_mis      <= w_mis;
        if (w_mis && r_cnt != CNT_SAT)
          r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    enable_ram = 1'b0;
    do_write   = 1'b0;
    flush      = 1'b0;
    case (r_state)
      IDLE: w_state_nx = RUN;
      RUN: begin
        enable_ram = ~stall;
        if (w_resolve && w_alloc)    w_state_nx = WRITE;
        else if (w_resolve && w_mis) w_state_nx = RECOVER;
      end
      RECOVER: begin
        enable_ram = 1'b1;
        flush      = 1'b1;
        w_state_nx = RUN;
      end
      WRITE: begin
        enable_ram = 1'b1;
        do_write   = 1'b1;
        flush      = r_mis;
        w_state_nx = RUN;
      end
      default: w_state_nx = IDLE;
    endcase
    // reset takes effect on outputs immediately, aborting RECOVER/WRITE
    if (reset) begin
      enable_ram = 1'b0;
      do_write   = 1'b0;
      flush      = 1'b0;
    end
    if (flush)
      next_pc = r_redirect;
    else if (bt_hit && bt_branch && !reset)
      next_pc = bt_target;
    else
      next_pc = fetch_pc + 32'd4;
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_btb_ctrl;
  localparam logic [15:0] SAT = 16'd600;

  logic        clock = 1'b0;
  logic        reset, stall, bt_hit, bt_branch, ex_valid, ex_is_branch, ex_taken;
  logic [31:0] fetch_pc, bt_target, ex_pc, ex_target;
  logic        enable_ram, do_write, flush;
  logic [31:0] next_pc;
  logic [15:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;

  btb_ctrl #(.CNT_SAT(SAT)) dut (
    .clock(clock), .reset(reset), .stall(stall), .fetch_pc(fetch_pc),
    .bt_hit(bt_hit), .bt_branch(bt_branch), .bt_target(bt_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .enable_ram(enable_ram),
    .do_write(do_write), .next_pc(next_pc), .flush(flush),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clock = ~clock;

  // behavioural model: records in program order, one pending redirect action
  typedef struct { bit v; bit h; bit pt; logic [31:0] tg; } mrec_t;
  mrec_t       m_rec [3];
  bit          m_started;
  int          m_pend;      // 0 none, 1 recover, 2 allocate-write
  bit          m_rmis;
  logic [31:0] m_redir;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    stall = 0; bt_hit = 0; bt_branch = 0; bt_target = 0;
    ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pc = 0; ex_target = 0;
  endtask

  // check outputs for the current inputs, advance the model, move to next cycle
  task automatic tick();
    bit e_en, e_dw, e_fl, res, act, mis, alloc;
    logic [31:0] e_np;
    int np;
    #1;
    if (reset) begin
      e_en = 0; e_dw = 0; e_fl = 0; e_np = fetch_pc + 32'd4;
    end else begin
      e_fl = (m_pend == 1) || (m_pend == 2 && m_rmis);
      e_dw = (m_pend == 2);
      e_en = !m_started ? 1'b0 : (m_pend != 0 ? 1'b1 : !stall);
      e_np = e_fl ? m_redir : ((bt_hit && bt_branch) ? bt_target : fetch_pc + 32'd4);
    end
    chk("enable_ram", {31'd0, enable_ram}, {31'd0, e_en});
    chk("do_write", {31'd0, do_write}, {31'd0, e_dw});
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    chk("next_pc", next_pc, e_np);
    chk("cnt", {16'd0, mispredict_cnt}, {16'd0, m_cnt});
    if (reset) begin
      foreach (m_rec[i]) m_rec[i] = '{0, 0, 0, 32'd0};
      m_started = 0; m_pend = 0; m_rmis = 0; m_redir = 0; m_cnt = 0;
    end else begin
      res   = m_started && m_pend == 0 && !stall && ex_valid && m_rec[2].v;
      act   = ex_is_branch && ex_taken;
      mis   = (act != m_rec[2].pt) || (act && m_rec[2].pt && ex_target != m_rec[2].tg);
      alloc = ex_is_branch && !m_rec[2].h;
      np    = res ? (alloc ? 2 : (mis ? 1 : 0)) : 0;
      if (res) begin
        m_redir = act ? ex_target : ex_pc + 32'd4;
        m_rmis  = mis;
        if (mis && m_cnt < SAT) m_cnt = m_cnt + 16'd1;
      end
      if (!stall) begin
        m_rec[2] = m_rec[1];
        m_rec[1] = m_rec[0];
        m_rec[0] = '{1, bt_hit, bt_hit && bt_branch, bt_target};
      end
      if (e_fl) begin m_rec[0].v = 0; m_rec[1].v = 0; end
      m_started = 1;
      m_pend    = np;
    end
    @(negedge clock);
  endtask

  // fetch a branch, two filler cycles, then present its resolution in EX
  task automatic branch_seq(input logic [31:0] pc, input bit hit, input bit br,
                            input logic [31:0] tg, input bit xb, input bit xt,
                            input logic [31:0] xtg, input bit st);
    set_idle(); fetch_pc = pc; bt_hit = hit; bt_branch = br; bt_target = tg; tick();
    set_idle(); fetch_pc = pc + 32'd4; tick();
    fetch_pc = pc + 32'd8; tick();
    fetch_pc = pc + 32'd12; ex_valid = 1; ex_is_branch = xb; ex_taken = xt;
    ex_pc = pc; ex_target = xtg; stall = st; tick();
    set_idle();
  endtask

  initial begin
    int budget;
    set_idle(); reset = 1; fetch_pc = 32'h40;
    @(negedge clock);
    bt_hit = 1; bt_branch = 1; bt_target = 32'h999;
    tick(); tick();
    reset = 1; #1;
    chk("rst_np", next_pc, 32'h44);
    chk("rst_en", {31'd0, enable_ram}, 32'd0);
    tick();

    // release: IDLE one cycle, then RUN
    set_idle(); reset = 0; fetch_pc = 32'h100; #1;
    chk("idle_en", {31'd0, enable_ram}, 32'd0);
    chk("idle_np", next_pc, 32'h104);
    tick(); #1;
    chk("run_en", {31'd0, enable_ram}, 32'd1);
    chk("run_np", next_pc, 32'h104);
    tick();

    // correctly predicted taken branch
    branch_seq(32'h1F0, 1, 1, 32'h200, 1, 1, 32'h200, 0); #1;
    chk("ok_flush", {31'd0, flush}, 32'd0);
    chk("ok_cnt", {16'd0, mispredict_cnt}, 32'd0);
    tick();

    // BTB miss on a taken branch -> allocate + redirect
    branch_seq(32'h300, 0, 0, 32'h0, 1, 1, 32'h400, 0); #1;
    chk("alloc_dw", {31'd0, do_write}, 32'd1);
    chk("alloc_fl", {31'd0, flush}, 32'd1);
    chk("alloc_np", next_pc, 32'h400);
    chk("alloc_cnt", {16'd0, mispredict_cnt}, 32'd1);
    tick();

    // predicted taken, resolved not-taken
    branch_seq(32'h500, 1, 1, 32'h600, 1, 0, 32'h600, 0); #1;
    chk("rec_fl", {31'd0, flush}, 32'd1);
    chk("rec_dw", {31'd0, do_write}, 32'd0);
    chk("rec_np", next_pc, 32'h504);
    tick();

    // fall-through wraps at 2^32
    branch_seq(32'hFFFFFFFC, 1, 1, 32'h40, 1, 0, 32'h40, 0); #1;
    chk("wrap_np", next_pc, 32'h0);
    chk("wrap_cnt", {16'd0, mispredict_cnt}, 32'd3);
    tick();

    // reset during WRITE aborts it
    branch_seq(32'h900, 0, 0, 32'h0, 1, 1, 32'hA00, 0);
    reset = 1; #1;
    chk("abort_dw", {31'd0, do_write}, 32'd0);
    chk("abort_fl", {31'd0, flush}, 32'd0);
    tick();
    reset = 0; tick(); tick();

    // stall at resolution delays the allocate
    branch_seq(32'h700, 0, 0, 32'h0, 1, 1, 32'h800, 1);
    ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_pc = 32'h700; ex_target = 32'h800; #1;
    chk("stall_dw", {31'd0, do_write}, 32'd0);
    tick(); set_idle(); #1;
    chk("stall_dw2", {31'd0, do_write}, 32'd1);
    chk("stall_np", next_pc, 32'h800);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 127) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      fetch_pc     = $urandom & 32'hFFFF_FFFC;
      bt_hit       = $urandom_range(0, 1);
      bt_branch    = $urandom_range(0, 1);
      bt_target    = $urandom_range(0, 3) << 4;
      ex_valid     = $urandom_range(0, 1);
      ex_is_branch = $urandom_range(0, 1);
      ex_taken     = $urandom_range(0, 1);
      ex_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom & 32'hFFFF_FFFC;
      ex_target    = $urandom_range(0, 1) ? m_rec[2].tg : ($urandom_range(0, 3) << 4);
      tick();
    end

    // drive the counter into saturation and hold it there
    set_idle(); reset = 0; budget = 0;
    bt_hit = 1; bt_branch = 1;
    ex_valid = 1; ex_is_branch = 1; ex_taken = 0;
    while (m_cnt != SAT && budget < 20000) begin
      fetch_pc = $urandom & 32'hFFFF_FFFC; bt_target = $urandom; ex_pc = fetch_pc;
      tick(); budget++;
    end
    if (budget >= 20000) chk("sat_budget", 32'd0, 32'd1);
    for (int i = 0; i < 40; i++) tick();
    #1;
    chk("sat_hold", {16'd0, mispredict_cnt}, {16'd0, SAT});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
